// File: rtl/hdmi_clk_pkg.sv
// hdmi_clk_pkg: shared types and constants for the HDMI clock-chain sequencer.
//   seq_state_e     - 3-bit FSM state with fixed debug encodings
//   seq_out_t       - the six sequencer outputs as one packed vector
//   DEF_*           - default timing constants for a 27 MHz oscillator
//   decode_outputs  - state -> output vector mapping
package hdmi_clk_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_DIV_REL   = 3'd3,
    ST_SER_REL   = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } seq_state_e;

  // Field order matches the bit order {pll_reset .. fault}, MSB first.
  typedef struct packed {
    logic pll_reset;
    logic clkdiv_resetn;
    logic serdes_rst;
    logic pix_rst;
    logic ready;
    logic fault;
  } seq_out_t;

  localparam int DEF_PLL_RST_CYC  = 16;
  localparam int DEF_LOCK_TIMEOUT = 270000;  // 10 ms at 27 MHz
  localparam int DEF_SETTLE_CYC   = 1024;
  localparam int DEF_DIV_CYC      = 32;
  localparam int DEF_LOSS_FILT    = 4;
  localparam int DEF_MAX_RETRY    = 3;

  // Anything not explicitly released is held in reset; an unused encoding
  // therefore decodes to the safe PLL_RST pattern.
  function automatic seq_out_t decode_outputs(input seq_state_e st);
    seq_out_t o;
    case (st)
      ST_WAIT_LOCK,
      ST_SETTLE:  o = seq_out_t'(6'b001100);
      ST_DIV_REL: o = seq_out_t'(6'b011100);
      ST_SER_REL: o = seq_out_t'(6'b010100);
      ST_RUN:     o = seq_out_t'(6'b010010);
      ST_FAULT:   o = seq_out_t'(6'b101101);
      default:    o = seq_out_t'(6'b101100);
    endcase
    return o;
  endfunction

endpackage

// File: rtl/lock_sync_filt.sv
// lock_sync_filt: brings the asynchronous rPLL LOCK into the oscillator
// domain and flags a sustained loss of lock.
//   clk, rst  - oscillator clock, synchronous active-high reset
//   pll_lock  - raw rPLL LOCK (asynchronous)
//   lock_s    - LOCK after a 2-FF synchronizer (2 cycles latency)
//   loss      - high while lock_s has been low for LOSS_FILT consecutive cycles
module lock_sync_filt
  import hdmi_clk_pkg::*;
#(
  parameter int LOSS_FILT = DEF_LOSS_FILT
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  output logic lock_s,
  output logic loss
);

  localparam int FW = (LOSS_FILT > 1) ? $clog2(LOSS_FILT) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(LOSS_FILT - 1);

  logic          meta_q;
  logic          sync_q;
  logic [FW-1:0] low_cnt_q;

  // NOTE: every register here is assigned with <= so all flops sample the
  // pre-edge values; blocking assignments would collapse the 2-FF chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      low_cnt_q <= '0;
    end else begin
      meta_q <= pll_lock;
      sync_q <= meta_q;
      // Saturating count of low samples already seen; the current low
      // sample completes the run, so loss asserts on the LOSS_FILT-th one.
      if (sync_q) begin
        low_cnt_q <= '0;
      end else if (low_cnt_q != FILT_LAST) begin
        low_cnt_q <= low_cnt_q + 1'b1;
      end
    end
  end

  assign lock_s = sync_q;
  assign loss   = !sync_q && (low_cnt_q == FILT_LAST);

endmodule

// File: rtl/hdmi_clk_seq.sv
// hdmi_clk_seq: power-up / recovery sequencer for rPLL -> CLKDIV -> OSER10
// -> pixel logic. Holds the PLL in reset, waits for a settled lock, then
// releases CLKDIV, serializers and pixel domain in strict order.
//   clk, rst       - oscillator clock, synchronous active-high reset
//   pll_lock       - rPLL LOCK (asynchronous)
//   restart        - single-cycle request to rerun the whole sequence
//   pll_reset      - rPLL RESET (active-high)
//   clkdiv_resetn  - CLKDIV RESETN (active-low)
//   serdes_rst     - OSER10 RESET (active-high)
//   pix_rst        - pixel-domain reset request (active-high)
//   ready, fault   - chain running / lock never achieved
//   state          - current FSM state, for debug
module hdmi_clk_seq
  import hdmi_clk_pkg::*;
#(
  parameter int PLL_RST_CYC  = DEF_PLL_RST_CYC,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int DIV_CYC      = DEF_DIV_CYC,
  parameter int LOSS_FILT    = DEF_LOSS_FILT,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       clkdiv_resetn,
  output logic       serdes_rst,
  output logic       pix_rst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  // One counter serves every timed state; LOCK_TIMEOUT is the longest
  // interval, so the other terminal counts fit in the same width.
  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(DIV_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRY);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d, retry_inc;
  seq_out_t         out_q;
  logic             lock_s;
  logic             loss;

  lock_sync_filt #(
    .LOSS_FILT (LOSS_FILT)
  ) u_lock (
    .clk      (clk),
    .rst      (rst),
    .pll_lock (pll_lock),
    .lock_s   (lock_s),
    .loss     (loss)
  );

  always_comb begin
    // NOTE: every variable written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    retry_inc = retry_q + 1'b1;

    // restart outranks loss and timeout in every state.
    if (restart) begin
      state_d = ST_PLL_RST;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == PLL_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_SETTLE;
          end else if (cnt_q == TO_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RTY_MAX) ? ST_FAULT : ST_PLL_RST;
          end
        end
        ST_SETTLE: begin
          // A dropout re-enters WAIT_LOCK with a fresh timeout; it is not
          // counted as a failed attempt.
          if (!lock_s)                   state_d = ST_WAIT_LOCK;
          else if (cnt_q == SETTLE_LAST) state_d = ST_DIV_REL;
        end
        ST_DIV_REL: begin
          if (loss)                   state_d = ST_PLL_RST;
          else if (cnt_q == DIV_LAST) state_d = ST_SER_REL;
        end
        ST_SER_REL: begin
          if (loss) begin
            state_d = ST_PLL_RST;
          end else if (cnt_q == DIV_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (loss) state_d = ST_PLL_RST;
        end
        ST_FAULT: ;
        default: state_d = ST_PLL_RST;
      endcase
    end

    // The shared counter restarts on every state change (and on restart,
    // even when already in PLL_RST); it is idle in RUN and FAULT.
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (state_q inside {ST_PLL_RST, ST_WAIT_LOCK, ST_SETTLE,
                                 ST_DIV_REL, ST_SER_REL}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state and registered, so they move on
  // the same edge as the state, all together and glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      out_q   <= decode_outputs(ST_PLL_RST);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      out_q   <= decode_outputs(state_d);
    end
  end

  assign pll_reset     = out_q.pll_reset;
  assign clkdiv_resetn = out_q.clkdiv_resetn;
  assign serdes_rst    = out_q.serdes_rst;
  assign pix_rst       = out_q.pix_rst;
  assign ready         = out_q.ready;
  assign fault         = out_q.fault;
  assign state         = state_q;

endmodule

// File: tb/tb_hdmi_clk_seq.sv
// tb_hdmi_clk_seq: directed bench for hdmi_clk_seq with small timing
// parameters. A cycle-stamped behavioural model predicts state and outputs
// every cycle; literal checkpoints at hand-computed cycles pin the model.
module tb_hdmi_clk_seq;

  localparam int P_PLL  = 4;
  localparam int P_TO   = 20;
  localparam int P_SET  = 8;
  localparam int P_DIV  = 4;
  localparam int P_FILT = 3;
  localparam int P_RTY  = 2;

  localparam int S_PLL = 0, S_WAIT = 1, S_SET = 2, S_DIV = 3,
                 S_SER = 4, S_RUN = 5, S_FLT = 6;

  logic       clk, rst, pll_lock, restart;
  logic       pll_reset, clkdiv_resetn, serdes_rst, pix_rst, ready, fault;
  logic [2:0] state;
  logic [5:0] outs;

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;  // edges since the last reset edge

  hdmi_clk_seq #(
    .PLL_RST_CYC  (P_PLL),
    .LOCK_TIMEOUT (P_TO),
    .SETTLE_CYC   (P_SET),
    .DIV_CYC      (P_DIV),
    .LOSS_FILT    (P_FILT),
    .MAX_RETRY    (P_RTY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock      (pll_lock),
    .restart       (restart),
    .pll_reset     (pll_reset),
    .clkdiv_resetn (clkdiv_resetn),
    .serdes_rst    (serdes_rst),
    .pix_rst       (pix_rst),
    .ready         (ready),
    .fault         (fault),
    .state         (state)
  );

  assign outs = {pll_reset, clkdiv_resetn, serdes_rst, pix_rst, ready, fault};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
  endtask

  // Output pattern {pll_reset,clkdiv_resetn,serdes_rst,pix_rst,ready,fault}.
  function automatic logic [5:0] exp_vec(input int s);
    case (s)
      S_WAIT, S_SET: return 6'b001100;
      S_DIV:         return 6'b011100;
      S_SER:         return 6'b010100;
      S_RUN:         return 6'b010010;
      S_FLT:         return 6'b101101;
      default:       return 6'b101100;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // Times are absolute edge stamps: a phase ends when (now - entry) reaches
  // its length. lock_s before edge n is the pll_lock sample from edge n-2.
  int  m_state = S_PLL;
  int  m_cyc   = 0;
  int  m_enter = 0;
  int  m_tmo   = 0;
  int  m_low   = 0;
  int  m_nxt, m_el;
  bit  m_ls, m_loss, m_valid = 1'b0;
  bit  m_hist[$];

  always @(posedge clk) begin
    m_cyc++;
    if (rst) begin
      m_state = S_PLL;
      m_enter = m_cyc;
      m_tmo   = 0;
      m_low   = 0;
      m_hist.delete();
      m_hist.push_back(1'b0);
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_ls   = (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : 1'b0;
      m_low  = m_ls ? 0 : m_low + 1;
      m_loss = (m_low >= P_FILT);
      m_el   = m_cyc - m_enter;
      m_nxt  = m_state;
      if (restart) begin
        m_nxt = S_PLL;
        m_tmo = 0;
      end else begin
        case (m_state)
          S_PLL:  if (m_el == P_PLL) m_nxt = S_WAIT;
          S_WAIT: if (m_ls) m_nxt = S_SET;
                  else if (m_el == P_TO) begin
                    m_tmo++;
                    m_nxt = (m_tmo == P_RTY) ? S_FLT : S_PLL;
                  end
          S_SET:  if (!m_ls) m_nxt = S_WAIT;
                  else if (m_el == P_SET) m_nxt = S_DIV;
          S_DIV:  if (m_loss) m_nxt = S_PLL;
                  else if (m_el == P_DIV) m_nxt = S_SER;
          S_SER:  if (m_loss) m_nxt = S_PLL;
                  else if (m_el == P_DIV) begin
                    m_nxt = S_RUN;
                    m_tmo = 0;
                  end
          S_RUN:  if (m_loss) m_nxt = S_PLL;
          default: ;
        endcase
      end
      if (restart || m_nxt != m_state) m_enter = m_cyc;
      m_state = m_nxt;
      m_hist.push_back(pll_lock);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
    end
  end

  // Continuous comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_state", 32'(state), 32'(m_state));
      check("model_outputs", 32'(outs), 32'(exp_vec(m_state)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    t   = 0;
  endtask

  task automatic pin(input string name, input int st, input logic [5:0] o);
    check({name, "_state"}, 32'(state), 32'(st));
    check({name, "_outputs"}, 32'(outs), 32'(o));
  endtask

  initial begin
    rst = 1'b1; pll_lock = 1'b0; restart = 1'b0;

    // Clean bring-up, lock rising 10 cycles after reset release.
    do_reset();
    pin("A_reset", 0, 6'b101100);
    run_to(3);  pin("A_pll_hold",  0, 6'b101100);
    run_to(4);  pin("A_pll_fall",  1, 6'b001100);
    run_to(10); pll_lock = 1'b1;
    run_to(12); pin("A_wait_sync", 1, 6'b001100);
    run_to(13); pin("A_settle",    2, 6'b001100);
    run_to(20); pin("A_settle_end",2, 6'b001100);
    run_to(21); pin("A_div_rel",   3, 6'b011100);
    run_to(24); pin("A_div_hold",  3, 6'b011100);
    run_to(25); pin("A_ser_rel",   4, 6'b010100);
    run_to(28); pin("A_ser_hold",  4, 6'b010100);
    run_to(29); pin("A_run",       5, 6'b010010);

    // Glitches in RUN: 2 low cycles filtered, 3 low cycles reset the chain.
    run_to(31); pll_lock = 1'b0;
    run_to(33); pll_lock = 1'b1;
    run_to(40); pin("A_glitch2", 5, 6'b010010);
    pll_lock = 1'b0;
    run_to(43); pll_lock = 1'b1;
    run_to(44); pin("A_glitch3_pre", 5, 6'b010010);
    run_to(45); pin("A_loss",        0, 6'b101100);
    run_to(66); pin("A_rerun",       5, 6'b010010);

    // Minimum-latency start with lock already high; 2-cycle drop in SETTLE.
    pll_lock = 1'b1;
    do_reset();
    run_to(5);  pin("B_settle", 2, 6'b001100);
    run_to(7);  pll_lock = 1'b0;
    run_to(9);  pll_lock = 1'b1;
    run_to(10); pin("B_drop",           1, 6'b001100);
    run_to(12); pin("B_resettle",       2, 6'b001100);
    run_to(19); pin("B_settle_restart", 2, 6'b001100);
    run_to(20); pin("B_div_rel",        3, 6'b011100);
    run_to(28); pin("B_run",            5, 6'b010010);
    run_to(30);

    // rst mid-RUN: reset values on the next edge.
    pll_lock = 1'b0;
    do_reset();
    pin("C_rst_midrun", 0, 6'b101100);

    // One timeout (retry=1), then restart and loss together in SER_REL.
    run_to(24); pin("C_timeout1", 0, 6'b101100);
    run_to(25); pll_lock = 1'b1;
    run_to(38); pll_lock = 1'b0;
    run_to(41); pin("C_ser", 4, 6'b010100);
    run_to(42); restart = 1'b1;
    run_to(43); pin("C_restart_loss", 0, 6'b101100);
    restart = 1'b0;
    run_to(66); pin("C_wait",          1, 6'b001100);
    run_to(67); pin("C_retry_cleared", 0, 6'b101100);

    // Lock never rises: two timeouts then FAULT; restart clears retry.
    do_reset();
    run_to(23);  pin("D_wait1",    1, 6'b001100);
    run_to(24);  pin("D_timeout1", 0, 6'b101100);
    run_to(28);  pin("D_wait2",    1, 6'b001100);
    run_to(47);  pin("D_wait2_end",1, 6'b001100);
    run_to(48);  pin("D_fault",    6, 6'b101101);
    run_to(52);  pin("D_fault_hold", 6, 6'b101101);
    restart = 1'b1;
    run_to(53);  pin("D_restart",  0, 6'b101100);
    restart = 1'b0;
    run_to(57);  pin("D_wait3",    1, 6'b001100);
    run_to(77);  pin("D_timeout3", 0, 6'b101100);
    run_to(81);  pin("D_wait4",    1, 6'b001100);
    run_to(101); pin("D_fault2",   6, 6'b101101);
    run_to(104);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
